// File: rtl/conv_encoder_tx.sv
// Rate-1/2 convolutional encoder that pulls words from a sync FIFO and emits
// a terminated symbol stream (data bits MSB-first, then K-1 zero tail bits).
module conv_encoder_tx #(
    parameter int             DATA_WIDTH = 16,
    parameter int             K          = 7,
    parameter logic [K-1:0]   G0         = 7'o171,
    parameter logic [K-1:0]   G1         = 7'o133
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic [15:0]           frame_words_i,
    output logic                  fifo_rd_en_o,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data_i,
    input  logic                  fifo_empty_i,
    output logic [1:0]            sym_o,
    output logic                  sym_valid_o,
    input  logic                  sym_ready_i,
    output logic                  sym_last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);
    localparam int TCW = $clog2(K);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_SHIFT,
        ST_TAIL,
        ST_DRAIN
    } state_t;

    state_t                  state_q;
    logic [K-2:0]            sr_q;
    logic [DATA_WIDTH-1:0]   word_q;
    logic [BCW-1:0]          bit_cnt_q;
    logic [TCW-1:0]          tail_cnt_q;
    logic [15:0]             words_q;
    logic [1:0]              sym_q;
    logic                    valid_q;
    logic                    last_q;
    logic                    done_q;

    logic                    in_bit;
    logic [K-1:0]            enc_v;
    logic [1:0]              sym_d;
    logic [K-2:0]            sr_d;
    logic                    slot_free;

    // Tail phase feeds zeros so the decoder trellis terminates in state 0.
    assign in_bit    = (state_q == ST_SHIFT) ? word_q[DATA_WIDTH-1] : 1'b0;
    assign enc_v     = {in_bit, sr_q};
    assign sym_d     = {^(G0 & enc_v), ^(G1 & enc_v)};
    assign sr_d      = {in_bit, sr_q[K-2:1]};
    assign slot_free = !valid_q || sym_ready_i;

    assign fifo_rd_en_o = (state_q == ST_FETCH) && !fifo_empty_i;
    assign sym_o        = sym_q;
    assign sym_valid_o  = valid_q;
    assign sym_last_o   = last_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sr_q       <= '0;
            word_q     <= '0;
            bit_cnt_q  <= '0;
            tail_cnt_q <= '0;
            words_q    <= '0;
            sym_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            // A completed handshake empties the slot unless a load below refills it.
            if (valid_q && sym_ready_i) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (start_i && (frame_words_i != '0)) begin
                        words_q <= frame_words_i;
                        sr_q    <= '0;
                        state_q <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    if (fifo_rd_en_o) begin
                        words_q <= words_q - 1'b1;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    word_q    <= fifo_rd_data_i;
                    bit_cnt_q <= BCW'(DATA_WIDTH);
                    state_q   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (slot_free) begin
                        sym_q     <= sym_d;
                        valid_q   <= 1'b1;
                        sr_q      <= sr_d;
                        word_q    <= word_q << 1;
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                        if (bit_cnt_q == BCW'(1)) begin
                            if (words_q != '0) begin
                                state_q <= ST_FETCH;
                            end else begin
                                tail_cnt_q <= TCW'(K - 1);
                                state_q    <= ST_TAIL;
                            end
                        end
                    end
                end
                ST_TAIL: begin
                    if (slot_free) begin
                        sym_q      <= sym_d;
                        valid_q    <= 1'b1;
                        sr_q       <= sr_d;
                        tail_cnt_q <= tail_cnt_q - 1'b1;
                        if (tail_cnt_q == TCW'(1)) begin
                            last_q  <= 1'b1;
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (sym_ready_i) begin
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Bench for conv_encoder_tx: FIFO model, symbol scoreboard fed by a reference
// tap-by-tap encoder, and a table of frames plus reset/control sequences.
module tb_conv_encoder_tx;

    localparam int DW = 16;
    localparam int K  = 7;
    localparam logic [K-1:0] G0P = 7'o171;
    localparam logic [K-1:0] G1P = 7'o133;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start_i = 1'b0;
    logic [15:0]   frame_words_i = '0;
    logic          fifo_rd_en_o;
    logic [DW-1:0] fifo_rd_data_i = '0;
    logic          fifo_empty_i = 1'b1;
    logic [1:0]    sym_o;
    logic          sym_valid_o;
    logic          sym_ready_i = 1'b1;
    logic          sym_last_o;
    logic          busy_o;
    logic          done_o;

    conv_encoder_tx #(.DATA_WIDTH(DW), .K(K), .G0(G0P), .G1(G1P)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .frame_words_i  (frame_words_i),
        .fifo_rd_en_o   (fifo_rd_en_o),
        .fifo_rd_data_i (fifo_rd_data_i),
        .fifo_empty_i   (fifo_empty_i),
        .sym_o          (sym_o),
        .sym_valid_o    (sym_valid_o),
        .sym_ready_i    (sym_ready_i),
        .sym_last_o     (sym_last_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sym;
        logic       last;
    } exp_t;

    typedef struct {
        int          nwords;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        int          ready_mode;
        int          pre;
        bit          poke;
        bit          imp;
    } frame_t;

    exp_t          exp_q[$];
    logic [1:0]    rx_q[$];
    logic [DW-1:0] fifo_q[$];
    frame_t        tbl[6];
    logic [1:0]    imp[22];

    int   checks = 0;
    int   errors = 0;
    int   rd_count = 0;
    int   ready_mode = 0;
    logic rd_seen = 1'b0;
    logic stall_prev = 1'b0;
    logic [1:0] stall_sym = '0;
    logic stall_last = 1'b0;
    exp_t mon_e;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference encoder: hist[j] is the input bit j steps ago; generator MSB taps hist[0].
    task automatic push_expected(input int n, input logic [DW-1:0] w0,
                                 input logic [DW-1:0] w1, input logic [DW-1:0] w2);
        logic [DW-1:0] ws[3];
        logic [K-1:0]  hist;
        logic [K-1:0]  g0v;
        logic [K-1:0]  g1v;
        logic          b;
        logic          g0;
        logic          g1;
        int            total;
        exp_t          e;
        ws[0] = w0; ws[1] = w1; ws[2] = w2;
        g0v = G0P; g1v = G1P;
        hist = '0;
        total = n * DW + K - 1;
        for (int t = 0; t < total; t++) begin
            b = (t < n * DW) ? ws[t / DW][DW - 1 - (t % DW)] : 1'b0;
            hist = {hist[K-2:0], b};
            g0 = 1'b0;
            g1 = 1'b0;
            for (int j = 0; j < K; j++) begin
                g0 = g0 ^ (g0v[K-1-j] & hist[j]);
                g1 = g1 ^ (g1v[K-1-j] & hist[j]);
            end
            e.sym  = {g0, g1};
            e.last = (t == total - 1);
            exp_q.push_back(e);
        end
    endtask

    // Output monitor: handshakes are sampled on the falling edge before the transfer edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
            rd_seen    = 1'b0;
        end else begin
            if (stall_prev)
                check("hold_while_stalled", {sym_valid_o, sym_o, sym_last_o},
                      {1'b1, stall_sym, stall_last});
            if (sym_valid_o && sym_ready_i) begin
                rx_q.push_back(sym_o);
                $display("sym %0d%0d last=%0d", sym_o[1], sym_o[0], sym_last_o);
                if (exp_q.size() == 0) begin
                    check("unexpected_sym", sym_valid_o, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("sym_and_last", {sym_o, sym_last_o}, {mon_e.sym, mon_e.last});
                end
            end
            stall_prev = sym_valid_o && !sym_ready_i;
            stall_sym  = sym_o;
            stall_last = sym_last_o;
            if (fifo_rd_en_o) begin
                rd_count++;
                check("rd_en_while_empty", fifo_empty_i, 0);
            end
            rd_seen = fifo_rd_en_o;
        end
    end

    // FIFO model (1-cycle read latency) and downstream ready generator.
    always @(posedge clk) begin
        #1;
        if (rd_seen && (fifo_q.size() != 0))
            fifo_rd_data_i = fifo_q.pop_front();
        fifo_empty_i = (fifo_q.size() == 0);
        sym_ready_i  = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    end

    task automatic run_frame(input frame_t f);
        logic [DW-1:0] ws[3];
        int rd0;
        int n;
        ws[0] = f.w0; ws[1] = f.w1; ws[2] = f.w2;
        rd0 = rd_count;
        ready_mode = f.ready_mode;
        rx_q.delete();
        push_expected(f.nwords, f.w0, f.w1, f.w2);
        for (int i = 0; i < f.pre; i++) fifo_q.push_back(ws[i]);
        repeat (2) @(posedge clk);
        #1;
        start_i = 1'b1;
        frame_words_i = 16'(f.nwords);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        frame_words_i = '0;
        check("busy_after_start", busy_o, 1);
        if (f.pre > 0) begin
            check("rd_en_on_fetch_entry", fifo_rd_en_o, 1);
            // First symbol appears 3 edges after the edge that accepted start_i.
            n = 0;
            while (!sym_valid_o && n < 10) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("first_valid_latency", n, 3);
        end
        if (f.poke) begin
            start_i = 1'b1;
            frame_words_i = 16'd5;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            frame_words_i = '0;
        end
        for (int i = f.pre; i < f.nwords; i++) begin
            repeat (20) @(posedge clk);
            #1;
            fifo_q.push_back(ws[i]);
        end
        n = 0;
        while (!done_o && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", done_o, 1);
        check("busy_at_done", busy_o, 0);
        check("valid_at_done", sym_valid_o, 0);
        @(posedge clk);
        #1;
        check("done_one_cycle", done_o, 0);
        check("fifo_reads", rd_count - rd0, f.nwords);
        check("expected_left", exp_q.size(), 0);
        if (f.imp) begin
            check("impulse_len", rx_q.size(), 22);
            for (int i = 0; i < 22; i++)
                if (i < rx_q.size()) check("impulse_sym", rx_q[i], imp[i]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0;
        int n;
        tbl[0] = '{1, 16'h8000, 16'h0000, 16'h0000, 0, 1, 1'b0, 1'b1}; // impulse
        tbl[1] = '{3, 16'h0000, 16'h0000, 16'h0000, 0, 3, 1'b0, 1'b0}; // zero frame
        tbl[2] = '{1, 16'h8000, 16'h0000, 16'h0000, 1, 1, 1'b0, 1'b1}; // backpressure
        tbl[3] = '{2, 16'hA5C3, 16'h1234, 16'h0000, 0, 1, 1'b0, 1'b0}; // starvation
        tbl[4] = '{1, 16'h8000, 16'h0000, 16'h0000, 0, 1, 1'b1, 1'b1}; // start while busy
        tbl[5] = '{3, 16'hDEAD, 16'hBEEF, 16'h0001, 1, 3, 1'b0, 1'b0}; // mixed data + stalls
        imp[0] = 2'b11; imp[1] = 2'b10; imp[2] = 2'b11; imp[3] = 2'b11;
        imp[4] = 2'b00; imp[5] = 2'b01; imp[6] = 2'b11;
        for (int i = 7; i < 22; i++) imp[i] = 2'b00;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs",
              {fifo_rd_en_o, sym_o, sym_valid_o, sym_last_o, busy_o, done_o}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) run_frame(tbl[i]);

        // Zero-length start must be ignored.
        rd0 = rd_count;
        start_i = 1'b1;
        frame_words_i = 16'd0;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (5) begin
            check("zero_start_idle", busy_o, 0);
            @(posedge clk);
            #1;
        end
        check("zero_start_no_read", rd_count - rd0, 0);

        // Reset in the middle of a frame, then a clean impulse frame.
        ready_mode = 0;
        push_expected(2, 16'hFFFF, 16'h1234, 16'h0000);
        fifo_q.push_back(16'hFFFF);
        fifo_q.push_back(16'h1234);
        repeat (2) @(posedge clk);
        #1;
        start_i = 1'b1;
        frame_words_i = 16'd2;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        n = 0;
        while (!sym_valid_o && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("mid_frame_valid", sym_valid_o, 1);
        rst_n = 1'b0;
        #1;
        check("reset_mid_outputs",
              {fifo_rd_en_o, sym_o, sym_valid_o, sym_last_o, busy_o, done_o}, 0);
        exp_q.delete();
        fifo_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_frame(tbl[0]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
